// File: rtl/paddle_ctl.sv
// Paddle position controller: synchronizes the up/down buttons and, once per
// frame at the vsync rising edge, moves the paddle with stepwise acceleration.
module paddle_ctl #(
  parameter int SCREEN_H   = 768,
  parameter int PADDLE_H   = 80,
  parameter int Y_INIT     = 344,
  parameter int V_MIN      = 1,
  parameter int V_MAX      = 8,
  parameter int ACC_FRAMES = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] y_pos,
  output logic        at_top,
  output logic        at_bottom
);

  localparam logic [11:0] Y_MAX    = 12'(SCREEN_H - PADDLE_H);
  localparam logic [11:0] Y_RST    = 12'(Y_INIT);
  localparam logic [11:0] SPD_MIN  = 12'(V_MIN);
  localparam logic [11:0] SPD_MAX  = 12'(V_MAX);
  localparam logic [7:0]  CNT_LAST = 8'(ACC_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  logic        r_up_meta, r_up_s, r_dn_meta, r_dn_s;
  logic        r_vsync_d;
  state_t      r_state;
  logic [11:0] r_speed;
  logic [7:0]  r_cnt;
  logic [11:0] r_y;
  logic        r_top, r_bot;

  logic        w_tick;
  state_t      w_nxt;
  logic        w_enter;
  logic [11:0] w_step;
  logic [11:0] w_y_nxt;
  logic [11:0] w_spd_nxt;
  logic [7:0]  w_cnt_nxt;

  // Upward move clamps at line 0 instead of wrapping.
  function automatic logic [11:0] sat_up(input logic [11:0] y, input logic [11:0] step);
    return (y < step) ? 12'd0 : y - step;
  endfunction

  // Downward move sums in 13 bits so a large step cannot wrap past the clamp.
  function automatic logic [11:0] sat_down(input logic [11:0] y, input logic [11:0] step);
    logic [12:0] sum;
    sum = {1'b0, y} + {1'b0, step};
    return (sum > {1'b0, Y_MAX}) ? Y_MAX : sum[11:0];
  endfunction

  assign w_tick = vsync_in & ~r_vsync_d;

  always_comb begin
    w_nxt = IDLE;
    if (r_up_s & ~r_dn_s)
      w_nxt = UP;
    else if (r_dn_s & ~r_up_s)
      w_nxt = DOWN;
    w_enter   = (w_nxt != r_state);
    w_step    = w_enter ? SPD_MIN : r_speed;
    w_y_nxt   = r_y;
    w_spd_nxt = SPD_MIN;
    w_cnt_nxt = 8'd0;
    case (w_nxt)
      UP:      w_y_nxt = sat_up(r_y, w_step);
      DOWN:    w_y_nxt = sat_down(r_y, w_step);
      default: w_y_nxt = r_y;
    endcase
    // A reversal counts as a fresh entry, so speed restarts from the minimum.
    if (w_nxt != IDLE) begin
      if (w_enter) begin
        w_spd_nxt = SPD_MIN;
        w_cnt_nxt = 8'd1;
      end else if (r_cnt == CNT_LAST) begin
        w_cnt_nxt = 8'd0;
        w_spd_nxt = (r_speed >= SPD_MAX) ? SPD_MAX : r_speed + 12'd1;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
        w_spd_nxt = r_speed;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_up_meta <= 1'b0;
      r_up_s    <= 1'b0;
      r_dn_meta <= 1'b0;
      r_dn_s    <= 1'b0;
      // Held at 1 so a vsync already high at reset release is not a tick.
      r_vsync_d <= 1'b1;
      r_state   <= IDLE;
      r_speed   <= SPD_MIN;
      r_cnt     <= 8'd0;
      r_y       <= Y_RST;
      r_top     <= 1'b0;
      r_bot     <= 1'b0;
    end else begin
      r_up_meta <= btn_up;
      r_up_s    <= r_up_meta;
      r_dn_meta <= btn_down;
      r_dn_s    <= r_dn_meta;
      r_vsync_d <= vsync_in;
      if (w_tick) begin
        r_state <= w_nxt;
        r_speed <= w_spd_nxt;
        r_cnt   <= w_cnt_nxt;
        r_y     <= w_y_nxt;
        r_top   <= (w_y_nxt == 12'd0);
        r_bot   <= (w_y_nxt == Y_MAX);
      end
    end
  end

  assign y_pos     = r_y;
  assign at_top    = r_top;
  assign at_bottom = r_bot;

endmodule

// File: tb/tb_paddle_ctl.sv
// Scoreboard bench for paddle_ctl: stimulus queues expected per-tick results,
// a monitor pops and compares them whenever a frame tick updates the outputs.
module tb_paddle_ctl;
  localparam int Y_MAX = 688;

  logic        pclk;
  logic        rst;
  logic        vsync_in;
  logic        btn_up;
  logic        btn_down;
  logic [11:0] y_pos;
  logic        at_top;
  logic        at_bottom;

  paddle_ctl dut (
    .pclk      (pclk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .y_pos     (y_pos),
    .at_top    (at_top),
    .at_bottom (at_bottom)
  );

  typedef struct {
    int y;
    bit chk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_n = 0;
  logic tb_vs_d = 1'b1;
  logic pend = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Independent tick model: rising vsync against a registered copy, masked by rst.
  always @(posedge pclk) begin
    pend    <= vsync_in && !tb_vs_d && !rst;
    tb_vs_d <= rst ? 1'b1 : vsync_in;
  end

  always @(negedge pclk) begin
    if (pend) begin
      exp_t e;
      tick_n++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got y_pos=%0d expected no tick", y_pos);
      end else begin
        e = q.pop_front();
        chk($sformatf("tick%0d_y_le_max", tick_n), int'(y_pos <= 12'(Y_MAX)), 1);
        if (e.chk) begin
          chk($sformatf("tick%0d_y_pos", tick_n), int'(y_pos), e.y);
          chk($sformatf("tick%0d_at_top", tick_n), int'(at_top), int'(e.y == 0));
          chk($sformatf("tick%0d_at_bottom", tick_n), int'(at_bottom), int'(e.y == Y_MAX));
        end
      end
    end
  end

  task automatic frame();
    vsync_in = 1'b0;
    repeat (3) @(negedge pclk);
    vsync_in = 1'b1;
    repeat (3) @(negedge pclk);
  endtask

  task automatic tick_exp(input int y);
    exp_t e;
    e.y   = y;
    e.chk = 1'b1;
    q.push_back(e);
    frame();
  endtask

  task automatic tick_free(input int n);
    exp_t e;
    e.y   = 0;
    e.chk = 1'b0;
    for (int i = 0; i < n; i++) begin
      q.push_back(e);
      frame();
    end
  endtask

  task automatic ticks(input int vals[]);
    foreach (vals[i]) tick_exp(vals[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; vsync_in = 1'b1; btn_up = 1'b0; btn_down = 1'b1;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_y_pos", int'(y_pos), 344);
    chk("reset_at_top", int'(at_top), 0);
    chk("reset_at_bottom", int'(at_bottom), 0);
    repeat (4) @(negedge pclk);
    chk("no_tick_vsync_high", int'(y_pos), 344);

    // Down held from 344 with acceleration after four moves.
    ticks('{345, 346, 347, 348, 350, 352, 354, 356});
    btn_down = 1'b0;
    tick_exp(356);

    // Six down ticks reach speed 2, then a reversal restarts at step 1.
    btn_down = 1'b1;
    ticks('{357, 358, 359, 360, 362, 364});
    btn_down = 1'b0; btn_up = 1'b1;
    tick_exp(363);
    btn_down = 1'b1;
    ticks('{363, 363});

    // Buttons toggled with vsync low must not move the paddle.
    vsync_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      btn_up   = i[0];
      btn_down = i[1];
      @(negedge pclk);
      chk($sformatf("no_tick_toggle%0d", i), int'(y_pos), 363);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    tick_exp(363);

    // Mid-frame reset while moving at speed 2.
    btn_down = 1'b1;
    ticks('{364, 365, 366, 367, 369});
    vsync_in = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk("midframe_rst_y_pos", int'(y_pos), 344);
    chk("midframe_rst_at_top", int'(at_top), 0);
    ticks('{345, 346, 347, 348, 350});

    // Reset coinciding with a vsync rise overrides the tick.
    vsync_in = 1'b0;
    repeat (3) @(negedge pclk);
    vsync_in = 1'b1; rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk("rst_vs_tick_y_pos", int'(y_pos), 344);
    repeat (3) @(negedge pclk);
    chk("rst_vs_tick_hold", int'(y_pos), 344);
    tick_exp(345);

    // Drive to the top, then set up y_pos=5 from there.
    btn_down = 1'b0; btn_up = 1'b1;
    tick_free(60);
    btn_up = 1'b0;
    tick_exp(0);
    btn_down = 1'b1;
    ticks('{1, 2, 3, 4});
    btn_down = 1'b0;
    tick_exp(4);
    btn_down = 1'b1;
    tick_exp(5);
    btn_down = 1'b0;
    tick_exp(5);
    btn_up = 1'b1;
    ticks('{4, 3, 2, 1, 0, 0, 0, 0});

    // Drive to the bottom, back off to 686, then hold down at the limit.
    btn_up = 1'b0; btn_down = 1'b1;
    tick_free(110);
    btn_down = 1'b0; btn_up = 1'b1;
    ticks('{687, 686});
    btn_up = 1'b0; btn_down = 1'b1;
    ticks('{687, 688});
    for (int i = 0; i < 10; i++) tick_exp(688);

    btn_down = 1'b0;
    vsync_in = 1'b0;
    repeat (4) @(negedge pclk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
